// File: rtl/online_log_taylor.sv
// Streaming ln(1+x) evaluator: 4-term Taylor series x - x^2/2 + x^3/3 - x^4/4.
// Q1.15 in, Q8.32 out, four register stages behind a global clock-enable.
module online_log_taylor (
    input  logic        clk,
    input  logic        nrst,
    input  logic        enable,
    input  logic [15:0] din_x,
    output logic [39:0] data_out
);

    localparam logic [80:0] ThirdK = 81'd1431655765;  // floor(2^32 / 3)

    // S1
    logic [15:0] x_q;
    logic [31:0] p2_q, p2_d;
    // S2
    logic [47:0] p3_q, p3_d;
    logic [63:0] p4_q, p4_d;
    logic [39:0] d12_q, d12_d;
    // S3
    logic [39:0] d12b_q;
    logic [39:0] t3_q, t3_d;
    logic [39:0] t4_q, t4_d;
    // S4
    logic [39:0] out_d;

    logic [31:0] x32;
    logic [47:0] x48, p2_48;
    logic [63:0] p2_64;
    logic [39:0] t1, t2;
    logic [34:0] p3s;
    logic [80:0] p3e, prod;

    // Operands are sign-extended to the product width, so modular products are exact.
    always_comb begin
        x32    = {{16{din_x[15]}}, din_x};
        p2_d   = x32 * x32;

        x48    = {{32{x_q[15]}}, x_q};
        p2_48  = {{16{p2_q[31]}}, p2_q};
        p3_d   = p2_48 * x48;
        p2_64  = {{32{p2_q[31]}}, p2_q};
        p4_d   = p2_64 * p2_64;
        t1     = {{7{x_q[15]}}, x_q, 17'b0};
        t2     = {{7{p2_q[31]}}, p2_q, 1'b0};
        d12_d  = t1 - t2;

        p3s    = 35'($signed(p3_q) >>> 13);
        p3e    = {{46{p3s[34]}}, p3s};
        prod   = p3e * ThirdK;
        t3_d   = 40'($signed(prod) >>> 32);
        t4_d   = 40'($signed(p4_q) >>> 30);

        out_d  = d12b_q + t3_q - t4_q;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            x_q      <= '0;
            p2_q     <= '0;
            p3_q     <= '0;
            p4_q     <= '0;
            d12_q    <= '0;
            d12b_q   <= '0;
            t3_q     <= '0;
            t4_q     <= '0;
            data_out <= '0;
        end else if (enable) begin
            x_q      <= din_x;
            p2_q     <= p2_d;
            p3_q     <= p3_d;
            p4_q     <= p4_d;
            d12_q    <= d12_d;
            d12b_q   <= d12_q;
            t3_q     <= t3_d;
            t4_q     <= t4_d;
            data_out <= out_d;
        end
    end

endmodule

// File: tb/tb_online_log_taylor.sv
// Scoreboard bench for online_log_taylor: driver pushes expected results, negedge monitor pops
// them when a tracked sample reaches data_out and checks that data_out holds otherwise.
module tb_online_log_taylor;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] din_x = '0;
    logic [39:0] data_out;

    int checks = 0;
    int fails  = 0;

    logic [39:0] exp_q[$];
    logic [39:0] exp_hold = '0;
    logic [2:0]  vl = '0;
    logic        fire = 1'b0;
    logic        rst_ev = 1'b0;
    logic        mon_on = 1'b0;

    online_log_taylor dut (
        .clk      (clk),
        .nrst     (nrst),
        .enable   (enable),
        .din_x    (din_x),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    // Independent model of the series using 64/128-bit integer arithmetic.
    function automatic logic [39:0] model(input logic [15:0] xi);
        longint x, p2, p3, p4, q, y;
        logic signed [127:0] w;
        x  = longint'($signed(xi));
        p2 = x * x;
        p3 = p2 * x;
        p4 = p2 * p2;
        q  = p3 >>> 13;
        w  = q;
        w  = w * 128'sd1431655765;
        w  = w >>> 32;
        y  = x * 131072 - p2 * 2 + longint'(w) - (p4 >>> 30);
        return y[39:0];
    endfunction

    // Tracks which enabled edges should deliver a scoreboard entry to data_out.
    always @(posedge clk) begin
        if (!nrst) begin
            vl     <= '0;
            fire   <= 1'b0;
            rst_ev <= 1'b1;
            exp_q.delete();
        end else begin
            rst_ev <= 1'b0;
            fire   <= enable && vl[2];
            if (enable) vl <= {vl[1:0], 1'b1};
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            if (rst_ev) exp_hold = '0;
            if (fire) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL scoreboard_underflow: output fired with no expected entry");
                end else begin
                    exp_hold = exp_q.pop_front();
                end
            end
            checks++;
            if (data_out !== exp_hold) begin
                fails++;
                $display("FAIL data_out t=%0t fire=%0b rst=%0b: got %h expected %h",
                         $time, fire, rst_ev, data_out, exp_hold);
            end
        end
    end

    task automatic drive(input logic [15:0] x, input logic en, input logic [39:0] exp_v);
        @(negedge clk);
        din_x  = x;
        enable = en;
        if (en && nrst) exp_q.push_back(exp_v);
    endtask

    // One reset edge with enable high and junk on din_x; the junk must never surface.
    task automatic do_reset();
        @(negedge clk);
        nrst   = 1'b0;
        enable = 1'b1;
        din_x  = 16'h7777;
        @(negedge clk);
        nrst   = 1'b1;
        enable = 1'b0;
    endtask

    localparam logic [39:0] YHalf  = 40'h0066AAAAAA;
    localparam logic [39:0] YMOne  = 40'hFDEAAAAAAB;
    localparam logic [39:0] YMHalf = 40'hFF51555555;

    initial begin
        repeat (3) @(negedge clk);
        mon_on = 1'b1;
        @(negedge clk);
        nrst = 1'b1;

        // Zero input stream
        repeat (8) drive(16'h0000, 1'b1, 40'h0);

        // Streaming directed vectors
        drive(16'h0000, 1'b1, 40'h0);
        drive(16'h4000, 1'b1, YHalf);
        drive(16'h8000, 1'b1, YMOne);
        drive(16'h0000, 1'b1, 40'h0);
        drive(16'hC000, 1'b1, YMHalf);
        drive(16'h4000, 1'b1, YHalf);

        // Stall with samples in flight
        repeat (5) drive(16'h5555, 1'b0, 40'h0);
        drive(16'h8000, 1'b1, YMOne);
        drive(16'hC000, 1'b1, YMHalf);
        drive(16'h4000, 1'b1, YHalf);
        repeat (2) drive(16'h0000, 1'b0, 40'h0);
        repeat (6) drive(16'h0000, 1'b1, 40'h0);

        // Reset mid-stream
        drive(16'h4000, 1'b1, YHalf);
        drive(16'h8000, 1'b1, YMOne);
        do_reset();
        drive(16'hC000, 1'b1, YMHalf);
        drive(16'h4000, 1'b1, YHalf);
        repeat (6) drive(16'h0000, 1'b1, 40'h0);

        // Boundaries through the model, then random stream with random stalls
        drive(16'h7FFF, 1'b1, model(16'h7FFF));
        drive(16'h8001, 1'b1, model(16'h8001));
        drive(16'h0001, 1'b1, model(16'h0001));
        drive(16'hFFFF, 1'b1, model(16'hFFFF));
        for (int i = 0; i < 4096; i++) begin
            logic [15:0] rx;
            logic        ren;
            rx  = 16'($urandom);
            ren = ($urandom_range(0, 3) != 0);
            drive(rx, ren, model(rx));
        end

        // Flush, then freeze: exactly the last three samples remain in flight
        repeat (8) drive(16'h0000, 1'b1, 40'h0);
        drive(16'h0000, 1'b0, 40'h0);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 3) begin
            fails++;
            $display("FAIL inflight_count: got %0d expected 3", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
